// File: rtl/i281_fetch_decode.sv
`default_nettype none
// ============================================================================
//  Module   : i281_fetch_decode
//  Purpose  : Instruction register, one-hot opcode decode, flags register,
//             run/single-step controller and fetched-instruction counter
//             feeding the i281 multicycle control FSM.
//  Revision : 1.0  initial release
// ============================================================================
module i281_fetch_decode #(
  parameter int IW = 16,  // instruction word width; field slicing assumes 16
  parameter int CW = 16   // width of the fetched-instruction counter
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          run_mode,
  input  logic          step_n,
  input  logic [IW-1:0] imem_data,
  input  logic          ir_we,
  input  logic [3:0]    alu_flags,
  input  logic          flags_we,
  output logic [26:0]   opcode_out,
  output logic [7:0]    imm_out,
  output logic [3:0]    flags_reg,
  output logic          run,
  output logic [CW-1:0] instr_count
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_FREE = 2'd1,
    ST_STEP = 2'd2
  } run_state_e;

  logic [IW-1:0] ir_q;
  logic [3:0]    flags_q;
  logic [CW-1:0] count_q;
  logic          step_s1_q;
  logic          step_s2_q;
  logic          step_prev_q;
  logic          step_evt_q;
  run_state_e    state_q;
  run_state_e    state_d;
  logic [22:0]   w_onehot;
  logic [3:0]    w_opcode;

  assign w_opcode = ir_q[15:12];

  // Instruction register: captures the IMEM word on the FSM fetch strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_q <= '0;
    end else if (ir_we) begin
      ir_q <= imem_data;
    end
  end

  // Flags register: written independently of the IR load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
    end else if (flags_we) begin
      flags_q <= alu_flags;
    end
  end

  // Fetched-instruction counter; counts every IR load and wraps naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (ir_we) begin
      count_q <= count_q + CW'(1);
    end
  end

  // Step button: two-flop synchronizer, previous-value flop and a registered
  // falling-edge pulse, so one press yields exactly one single-cycle event.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step_s1_q   <= 1'b1;
      step_s2_q   <= 1'b1;
      step_prev_q <= 1'b1;
      step_evt_q  <= 1'b0;
    end else begin
      step_s1_q   <= step_n;
      step_s2_q   <= step_s1_q;
      step_prev_q <= step_s2_q;
      step_evt_q  <= step_prev_q & ~step_s2_q;
    end
  end

  // Run controller state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_HALT;
    end else begin
      state_q <= state_d;
    end
  end

  // Run controller next state; run is a Moore decode of the state.
  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      ST_HALT: begin
        // continuous mode wins over a coincident step press
        if (run_mode) begin
          state_d = ST_FREE;
        end else if (step_evt_q) begin
          state_d = ST_STEP;
        end
      end
      ST_FREE: begin
        run = 1'b1;
        if (ir_we && !run_mode) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        // further presses are ignored until this instruction is fetched
        run = 1'b1;
        if (ir_we) begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // Opcode decode: one-hot instruction select from the IR opcode and sub-fields.
  always_comb begin
    w_onehot = '0;
    case (w_opcode)
      4'h0: w_onehot[0] = 1'b1;
      4'h1: begin
        case (ir_q[9:8])
          2'b00:   w_onehot[1] = 1'b1;
          2'b01:   w_onehot[2] = 1'b1;
          2'b10:   w_onehot[3] = 1'b1;
          default: w_onehot[4] = 1'b1;
        endcase
      end
      4'h2: w_onehot[5]  = 1'b1;
      4'h3: w_onehot[6]  = 1'b1;
      4'h4: w_onehot[7]  = 1'b1;
      4'h5: w_onehot[8]  = 1'b1;
      4'h6: w_onehot[9]  = 1'b1;
      4'h7: w_onehot[10] = 1'b1;
      4'h8: w_onehot[11] = 1'b1;
      4'h9: w_onehot[12] = 1'b1;
      4'hA: w_onehot[13] = 1'b1;
      4'hB: w_onehot[14] = 1'b1;
      4'hC: begin
        if (ir_q[8]) begin
          w_onehot[16] = 1'b1;
        end else begin
          w_onehot[15] = 1'b1;
        end
      end
      4'hD: w_onehot[17] = 1'b1;
      4'hE: w_onehot[18] = 1'b1;
      default: begin
        case (ir_q[9:8])
          2'b00:   w_onehot[19] = 1'b1;
          2'b01:   w_onehot[20] = 1'b1;
          2'b10:   w_onehot[21] = 1'b1;
          default: w_onehot[22] = 1'b1;
        endcase
      end
    endcase
  end

  // RX/RY are passed through raw even for sub-decoded opcodes.
  assign opcode_out  = {ir_q[11:8], w_onehot};
  assign imm_out     = ir_q[7:0];
  assign flags_reg   = flags_q;
  assign instr_count = count_q;

endmodule
`default_nettype wire
